// File: rtl/filter_tap_sequencer.sv
// filter_tap_sequencer: accepts one input sample per filter evaluation,
// writes it into the circular sample memory, and sweeps all taps while
// driving the accumulator enable/load pair. The enable/load pair is delayed
// to line up with the memory read and multiplier latency. The final
// accumulator sum is rounded and saturated, then offered on a valid/ready
// output port.
module filter_tap_sequencer #(
  parameter int ADDR_W = 5,
  parameter int PIPE   = 2,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              smp_we,
  output logic [ADDR_W-1:0] smp_waddr,
  output logic [15:0]       smp_wdata,
  output logic [ADDR_W-1:0] smp_raddr,
  output logic [ADDR_W-1:0] coef_raddr,
  output logic              acc_enable,
  output logic              acc_load,
  input  logic [39:0]       acc_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
);

  localparam int NTAPS = 1 << ADDR_W;
  localparam int ACC_W = 40;

  localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'(-(64'sd1 <<< (OUT_W - 1)));

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    CAPTURE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] k;
  logic [PIPE-1:0]   tap_pipe;
  logic [PIPE-1:0]   first_pipe;

  logic              accept;
  logic              tap_valid;
  logic              first_tap;

  logic signed [ACC_W:0]   acc_ext;
  logic signed [ACC_W:0]   rounded_sum;
  logic signed [ACC_W:0]   shifted;
  logic        [OUT_W-1:0] sat_data;

  // Handshake, memory addressing and accumulator controls derived from state
  assign in_ready   = (state == IDLE);
  assign accept     = in_valid & in_ready;
  assign smp_we     = accept;
  assign smp_waddr  = wr_ptr;
  assign smp_wdata  = in_data;
  assign coef_raddr = k;
  assign smp_raddr  = base - k;
  assign tap_valid  = (state == RUN);
  assign first_tap  = (state == RUN) && (k == '0);
  assign acc_enable = tap_pipe[PIPE-1];
  assign acc_load   = first_pipe[PIPE-1];

  // Round half up by adding half an output LSB, drop fractional bits, then clamp
  always_comb begin
    acc_ext     = {acc_q[ACC_W-1], acc_q};
    rounded_sum = acc_ext + HALF;
    shifted     = rounded_sum >>> SHIFT;
    sat_data    = shifted[OUT_W-1:0];
    if (shifted > OUT_MAX) begin
      sat_data = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < OUT_MIN) begin
      sat_data = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  // Sequencer FSM with tap pipeline, write pointer and registered output port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      base       <= '0;
      k          <= '0;
      tap_pipe   <= '0;
      first_pipe <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      tap_pipe[0]   <= tap_valid;
      first_pipe[0] <= first_tap;
      for (int i = 1; i < PIPE; i++) begin
        tap_pipe[i]   <= tap_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
      end

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            base   <= wr_ptr;
            wr_ptr <= wr_ptr + 1'b1;
            k      <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (k == ADDR_W'(NTAPS - 1)) begin
            k     <= '0;
            state <= DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          if (k == ADDR_W'(PIPE - 1)) begin
            k     <= '0;
            state <= CAPTURE;
          end else begin
            k <= k + 1'b1;
          end
        end
        CAPTURE: begin
          if (!out_valid || out_ready) begin
            out_data  <= sat_data;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_tap_sequencer.sv
// Testbench for filter_tap_sequencer: models the sample memory, coefficient
// memory, multiplier register and 40-bit accumulator around the DUT, and
// checks filtered outputs against a convolution model through a scoreboard.
module tb_filter_tap_sequencer;

  localparam int ADDR_W = 5;
  localparam int NTAPS  = 32;
  localparam int PIPE   = 2;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 15;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_data = '0;
  logic               smp_we;
  logic [ADDR_W-1:0]  smp_waddr;
  logic [15:0]        smp_wdata;
  logic [ADDR_W-1:0]  smp_raddr;
  logic [ADDR_W-1:0]  coef_raddr;
  logic               acc_enable;
  logic               acc_load;
  logic signed [39:0] acc_q = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;

  logic signed [15:0] smp_mem  [NTAPS];
  logic signed [15:0] coef_mem [NTAPS];
  logic signed [15:0] smp_q;
  logic signed [15:0] coef_q;
  logic signed [31:0] prod;

  logic signed [15:0] hist [NTAPS];
  int                 model_wptr = 0;
  logic signed [15:0] exp_q [$];

  int vectors     = 0;
  int miscompares = 0;

  filter_tap_sequencer #(
    .ADDR_W(ADDR_W),
    .PIPE  (PIPE),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .smp_we    (smp_we),
    .smp_waddr (smp_waddr),
    .smp_wdata (smp_wdata),
    .smp_raddr (smp_raddr),
    .coef_raddr(coef_raddr),
    .acc_enable(acc_enable),
    .acc_load  (acc_load),
    .acc_q     (acc_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Synchronous memories, multiplier register and accumulator feeding acc_q
  always @(posedge clk) begin
    if (smp_we) smp_mem[smp_waddr] <= $signed(smp_wdata);
    smp_q  <= smp_mem[smp_raddr];
    coef_q <= coef_mem[coef_raddr];
    prod   <= smp_q * coef_q;
    if (acc_enable) acc_q <= acc_load ? 40'(prod) : acc_q + 40'(prod);
  end

  // Bound total runtime
  initial begin
    repeat (30000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no finish, expected finish within 30000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic timeoutFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got timeout, expected completion", name);
  endtask

  // Reference: direct convolution over the model history, rounded half up and clamped
  function automatic logic signed [15:0] modelOut(input int b);
    longint sum;
    longint r;
    sum = 0;
    for (int t = 0; t < NTAPS; t++) begin
      sum += longint'(coef_mem[t]) * longint'(hist[(b - t) & (NTAPS - 1)]);
    end
    r = (sum + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (r > 32767) return 16'sh7fff;
    if (r < -32768) return 16'sh8000;
    return 16'(r);
  endfunction

  // Scoreboard monitor: every output handshake pops and compares one expectation
  always @(negedge clk) begin
    logic signed [15:0] e;
    if (rst_n && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        timeoutFail("unexpected_output");
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_data", 64'(out_data), 64'(e));
      end
    end
  end

  task automatic applyStimulus(input logic signed [15:0] x, input bit push);
    int waited;
    int b;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = x;
    waited   = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 400);
    if (!in_ready) begin
      timeoutFail("accept");
      in_valid = 1'b0;
      return;
    end
    checkOutput("smp_we", 64'(smp_we), 64'(1));
    checkOutput("smp_waddr", 64'(smp_waddr), 64'(model_wptr));
    checkOutput("smp_wdata", 64'($signed(smp_wdata)), 64'(x));
    b          = model_wptr;
    hist[b]    = x;
    model_wptr = (model_wptr + 1) % NTAPS;
    if (push) exp_q.push_back(modelOut(b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeoutFail(name);
  endtask

  logic signed [15:0] round_in  [4] = '{16'sd16384, -16'sd16385, -16'sd16384, 16'sd16383};
  logic signed [15:0] round_exp [4] = '{16'sd1, -16'sd1, 16'sd0, 16'sd0};

  initial begin
    int load_cnt, load_rel, en_cnt, en_first, ov_rel, n;

    for (int i = 0; i < NTAPS; i++) begin
      smp_mem[i]  = '0;
      hist[i]     = '0;
      coef_mem[i] = 16'(1000 * (i + 1));
    end

    // Reset state
    #2;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_data", 64'(out_data), 64'(0));
    checkOutput("rst_acc_enable", 64'(acc_enable), 64'(0));
    checkOutput("rst_acc_load", 64'(acc_load), 64'(0));
    checkOutput("rst_smp_we", 64'(smp_we), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Impulse with pipeline alignment check on the first sample
    out_ready = 1'b1;
    applyStimulus(16'sd32767, 1'b1);
    load_cnt = 0; load_rel = -1; en_cnt = 0; en_first = -1; ov_rel = -1;
    for (int rel = 0; rel < 40; rel++) begin
      @(negedge clk);
      if (rel == 1) checkOutput("smp_raddr_wrap", 64'(smp_raddr), 64'(NTAPS - 1));
      if (acc_load) begin
        load_cnt++;
        if (load_rel < 0) load_rel = rel;
      end
      if (acc_enable) begin
        en_cnt++;
        if (en_first < 0) en_first = rel;
      end
      if (out_valid && ov_rel < 0) ov_rel = rel;
    end
    checkOutput("load_count", 64'(load_cnt), 64'(1));
    checkOutput("load_cycle", 64'(load_rel), 64'(PIPE));
    checkOutput("enable_count", 64'(en_cnt), 64'(NTAPS));
    checkOutput("enable_first", 64'(en_first), 64'(PIPE));
    checkOutput("out_valid_rise", 64'(ov_rel), 64'(35));
    checkOutput("impulse_first", 64'(out_data), 64'(1000));
    for (int i = 1; i < NTAPS; i++) applyStimulus(16'sd0, 1'b1);
    waitDrain("impulse_drain");
    checkOutput("impulse_last", 64'(out_data), 64'(31999));

    // Saturation in both directions
    for (int i = 0; i < NTAPS; i++) coef_mem[i] = 16'sd32767;
    for (int i = 0; i < NTAPS; i++) applyStimulus(16'sd32767, 1'b1);
    waitDrain("sat_pos_drain");
    checkOutput("sat_pos", 64'(out_data), 64'(32767));
    for (int i = 0; i < NTAPS; i++) applyStimulus(-16'sd32768, 1'b1);
    waitDrain("sat_neg_drain");
    checkOutput("sat_neg", 64'(out_data), -64'sd32768);

    // Rounding boundaries with a unit tap 0
    for (int i = 0; i < NTAPS; i++) coef_mem[i] = '0;
    coef_mem[0] = 16'sd1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(round_in[i], 1'b1);
      waitDrain("round_drain");
      checkOutput("round", 64'(out_data), 64'(round_exp[i]));
    end

    // Backpressure: second result waits in CAPTURE without disturbing the first
    coef_mem[0] = 16'sd16384;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(16'sd1000, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeoutFail("bp_first_valid");
    applyStimulus(16'sd2000, 1'b1);
    for (int rel = 0; rel < 48; rel++) begin
      @(negedge clk);
      if (rel >= 36 && rel % 4 == 0) begin
        checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
        checkOutput("bp_acc_enable", 64'(acc_enable), 64'(0));
        checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
        checkOutput("bp_out_data", 64'(out_data), 64'(500));
        checkOutput("bp_acc_q", 64'(acc_q), 64'(32768000));
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain("bp_drain");
    checkOutput("bp_last", 64'(out_data), 64'(1000));

    // Reset mid-RUN at k = 10, then the next sample must restart at address 0
    coef_mem[1] = 16'sd8192;
    applyStimulus(16'sd5000, 1'b0);
    for (int rel = 0; rel <= 10; rel++) @(negedge clk);
    checkOutput("mid_coef_raddr", 64'(coef_raddr), 64'(10));
    checkOutput("mid_smp_raddr", 64'(smp_raddr), 64'((model_wptr - 1 - 10) & (NTAPS - 1)));
    rst_n = 1'b0;
    model_wptr = 0;
    #1;
    checkOutput("mid_rst_acc_enable", 64'(acc_enable), 64'(0));
    checkOutput("mid_rst_acc_load", 64'(acc_load), 64'(0));
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("mid_rst_out_data", 64'(out_data), 64'(0));
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("mid_rst_smp_we", 64'(smp_we), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'sd3000, 1'b1);
    waitDrain("post_reset_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
